// File: rtl/intmul_sched_pkg.sv
// Shared types and constants for the round-robin multiplier scheduler.
package intmul_sched_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } sched_state_e;

  localparam int DEF_LAT  = 3;
  localparam int DEF_NREQ = 4;
  localparam int DEF_IDW  = $clog2(DEF_NREQ);

  // Requester id width; a single requester still needs one bit of id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intmul_sched_tagpipe.sv
// Tag pipeline that shadows the fixed-latency multiplier: one {valid, id}
// per stage, the last stage marks which requester owns the current product.
module intmul_sched_tagpipe
  import intmul_sched_pkg::*;
#(
  parameter int LAT = DEF_LAT,
  parameter int IDW = DEF_IDW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [IDW-1:0] in_id,
  output logic           out_valid,
  output logic [IDW-1:0] out_id,
  output logic           any_valid
);

  logic [LAT-1:0] r_vld;
  logic [IDW-1:0] r_id [LAT];

  // Shift tags one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int k = 0; k < LAT; k++) begin
        r_id[k] <= '0;
      end
    end else begin
      r_vld[0] <= in_valid;
      r_id[0]  <= in_id;
      for (int k = 1; k < LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_id[k]  <= r_id[k-1];
      end
    end
  end

  assign out_valid = r_vld[LAT-1];
  assign out_id    = r_id[LAT-1];
  assign any_valid = |r_vld;

endmodule

// File: rtl/intmul_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency multiplier among NREQ
// requesters, with flush/drain. Define INTMUL_SCHED_PERF_EN for perf counters.
module intmul_rr_sched
  import intmul_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LOGA = 60,
  parameter int LOGB = 60,
  parameter int LAT  = DEF_LAT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*LOGA-1:0]   req_A,
  input  logic [NREQ*LOGB-1:0]   req_B,
  output logic [LOGA-1:0]        mul_A,
  output logic [LOGB-1:0]        mul_B,
  input  logic [LOGA+LOGB-1:0]   mul_C,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [LOGA+LOGB-1:0]   rsp_C,
  input  logic                   flush,
  output logic                   flush_done,
`ifdef INTMUL_SCHED_PERF_EN
  output logic [31:0]            perf_issue,
  output logic [31:0]            perf_idle,
`endif
  output logic                   busy
);

  localparam int             IDW     = id_width(NREQ);
  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  sched_state_e   r_state;
  sched_state_e   w_state_nxt;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW:0]   w_scan;
  logic           w_gnt_vld;
  logic [IDW-1:0] w_gnt_id;
  logic           w_issue;
  logic           w_tp_vld;
  logic [IDW-1:0] w_tp_id;
  logic           w_tp_any;
  logic           w_rsp_any;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_scan >= NREQ_W) begin
        w_scan = w_scan - NREQ_W;
      end else begin
        w_scan = w_scan;
      end
      if (!w_gnt_vld && req_valid[w_scan[IDW-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_scan[IDW-1:0];
      end else begin
        w_gnt_vld = w_gnt_vld;
      end
    end
  end

  // Flush wins over a same-cycle request, and reset silences every output.
  assign w_issue = (r_state == ST_RUN) && !flush && !rst && w_gnt_vld;

  always_comb begin
    req_ready = '0;
    mul_A     = '0;
    mul_B     = '0;
    if (w_issue) begin
      req_ready[w_gnt_id] = 1'b1;
      mul_A = req_A[int'(w_gnt_id)*LOGA +: LOGA];
      mul_B = req_B[int'(w_gnt_id)*LOGB +: LOGB];
    end else begin
      req_ready = '0;
    end
  end

  intmul_sched_tagpipe #(
    .LAT (LAT),
    .IDW (IDW)
  ) u_tagpipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_issue),
    .in_id     (w_gnt_id),
    .out_valid (w_tp_vld),
    .out_id    (w_tp_id),
    .any_valid (w_tp_any)
  );

  assign w_rsp_any  = w_tp_vld && !rst;
  assign rsp_C      = w_rsp_any ? mul_C : '0;
  assign busy       = w_tp_any && !rst;
  assign flush_done = (r_state == ST_DONE) && !rst;

  always_comb begin
    rsp_valid = '0;
    if (w_rsp_any) begin
      rsp_valid[w_tp_id] = 1'b1;
    end else begin
      rsp_valid = '0;
    end
  end

  // An empty pipeline at flush time skips DRAIN and goes straight to DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (flush) begin
          w_state_nxt = w_tp_any ? ST_DRAIN : ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: w_state_nxt = w_tp_any ? ST_DRAIN : ST_DONE;
      ST_DONE:  w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_rr_ptr <= (w_gnt_id == LAST_ID) ? '0 : w_gnt_id + IDW'(1);
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
    end
  end

`ifdef INTMUL_SCHED_PERF_EN
  logic [31:0] r_perf_issue;
  logic [31:0] r_perf_idle;

  // Saturating counters of issues and idle RUN cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_issue <= 32'd0;
      r_perf_idle  <= 32'd0;
    end else begin
      if (w_issue && (r_perf_issue != 32'hFFFF_FFFF)) begin
        r_perf_issue <= r_perf_issue + 32'd1;
      end
      if ((r_state == ST_RUN) && (req_valid == '0) && (r_perf_idle != 32'hFFFF_FFFF)) begin
        r_perf_idle <= r_perf_idle + 32'd1;
      end
    end
  end

  assign perf_issue = r_perf_issue;
  assign perf_idle  = r_perf_idle;
`endif

endmodule
